cpu_alu_arb: RTL

CPU_ALU_ARB -- requirements
Module: cpu_alu_arb

---
 rtl/cpu_alu_arb.sv | 121 ++++++++++++
 1 files changed

// File: rtl/cpu_alu_arb.sv
// cpu_alu_arb: shares one cpu_alu between two requesters through an IDLE/EXEC/RESP handshake FSM.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default is fixed priority with requester 0 first.
module cpu_alu #(
    parameter int W = 10
) (
    input  logic [2:0]   op,
    input  logic         si,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r,
    output logic         so
);
    logic unused_si;
    assign unused_si = si;
    // So is the carry/borrow for add/sub; every other op zero-extends.
    always_comb begin
        {so, r} = op == 3'b100 ? {1'b0, a} + {1'b0, b} :
                  op == 3'b101 ? {1'b0, a} - {1'b0, b} :
                  op == 3'b110 ? {1'b0, a & b} :
                  op == 3'b111 ? {1'b0, a | b} :
                  op == 3'b001 ? {{W{1'b0}}, a < b} :
                                 {1'b0, a};
    end
endmodule

module cpu_alu_arb #(
    parameter int REG_WID = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [2:0]         req0_op,
    input  logic               req0_si,
    input  logic [REG_WID-1:0] req0_a,
    input  logic [REG_WID-1:0] req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [2:0]         req1_op,
    input  logic               req1_si,
    input  logic [REG_WID-1:0] req1_a,
    input  logic [REG_WID-1:0] req1_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [REG_WID-1:0] rsp_r,
    output logic               rsp_so
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, nxt;
    logic gnt0, gnt1, acc, id_q, si_q, alu_so;
    logic [2:0] op_q;
    logic [REG_WID-1:0] a_q, b_q, alu_r;

`ifdef ALU_ARB_RR_EN
    logic last;
    always_ff @(posedge clk) begin
        if (rst) last <= 1'b1;
        else if (acc) last <= gnt1;
    end
    assign gnt0 = req0_valid && (!req1_valid || last);
`else
    assign gnt0 = req0_valid;
`endif
    assign gnt1 = req1_valid && !gnt0;
    assign acc  = req0_ready || req1_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    always_comb begin
        nxt = state == IDLE ? (acc ? EXEC : IDLE) :
              state == EXEC ? RESP :
              (rsp_ready ? IDLE : RESP);
    end

    always_comb begin
        req0_ready = !rst && state == IDLE && gnt0;
        req1_ready = !rst && state == IDLE && gnt1;
        rsp_valid  = state == RESP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            si_q <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            id_q <= 1'b0;
        end else if (acc) begin
            op_q <= req1_ready ? req1_op : req0_op;
            si_q <= req1_ready ? req1_si : req0_si;
            a_q  <= req1_ready ? req1_a : req0_a;
            b_q  <= req1_ready ? req1_b : req0_b;
            id_q <= req1_ready;
        end
    end

    cpu_alu #(.W(REG_WID)) u_alu (
        .op(op_q),
        .si(si_q),
        .a (a_q),
        .b (b_q),
        .r (alu_r),
        .so(alu_so)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_r  <= '0;
            rsp_so <= 1'b0;
            rsp_id <= 1'b0;
        end else if (state == EXEC) begin
            rsp_r  <= alu_r;
            rsp_so <= alu_so;
            rsp_id <= id_q;
        end
    end
endmodule
